// File: rtl/rbus_pkt_buffer_if.sv
// Word bus of the two-lane packet buffer: upstream write side, downstream read side, error flag.
interface rbus_pkt_buffer_if;
    logic        i_stb;
    logic        i_sof;
    logic [71:0] i_data;
    logic [1:0]  i_rdy;
    logic [1:0]  i_rdyE;
    logic        o_stb;
    logic        o_sof;
    logic [71:0] o_data;
    logic [1:0]  o_rdy;
    logic [1:0]  o_rdyE;
    logic        ff_err;

    modport slave (
        input  i_stb, i_sof, i_data, o_rdy, o_rdyE,
        output i_rdy, i_rdyE, o_stb, o_sof, o_data, ff_err
    );
    modport master (
        output i_stb, i_sof, i_data, o_rdy, o_rdyE,
        input  i_rdy, i_rdyE, o_stb, o_sof, o_data, ff_err
    );
endinterface

// File: rtl/rbus_pkt_buffer.sv
// Two-lane store-and-forward packet buffer: lane 1 has priority, packets leave only when complete.
module rbus_pkt_buffer #(
    parameter int DEPTH = 32
) (
    input logic              clk,
    input logic              rst,
    rbus_pkt_buffer_if.slave bus
);
    localparam int          AW     = $clog2(DEPTH);
    localparam int          CW     = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] MAXPKT = CW'(9);

    typedef enum logic {IDLE, SEND} state_t;

    // Both lanes share one array; the lane number is the address MSB.
    logic [71:0] mem [2*DEPTH];

    logic [1:0]         wr_en, rd_en, pop, push_a, push_b;
    logic [1:0][CW-1:0] free, pkt_cnt;
    logic [1:0][AW-1:0] wr_ptr, rd_ptr;
    logic [1:0][3:0]    head_len;

    logic       busy_reg, lane_reg, err_reg;
    logic [3:0] left_reg, stored_reg;
    logic       ca_v_reg, ca_lane_reg, cb_v_reg, cb_lane_reg;
    logic [3:0] ca_len_reg, cb_len_reg;

    logic       hdr, cont, len_big, wl, mem_we, close_a, close_b, proto_err;
    logic [3:0] hdr_len, b_len;

    state_t      state_reg;
    logic        sel_reg, first_reg, o_stb_reg, o_sof_reg;
    logic [3:0]  left_rd_reg;
    logic [71:0] o_data_reg;
    logic        start, next_sel;

    logic unused_rdye;
    assign unused_rdye = ^bus.o_rdyE;

    always_comb begin
        hdr       = bus.i_stb && bus.i_sof;
        cont      = bus.i_stb && !bus.i_sof && busy_reg;
        len_big   = bus.i_data[67:64] > 4'd8;
        hdr_len   = len_big ? 4'd9 : bus.i_data[67:64] + 4'd1;
        wl        = hdr ? bus.i_data[71] : lane_reg;
        mem_we    = (hdr || cont) && (free[wl] != '0);
        b_len     = (hdr ? 4'd0 : stored_reg) + 4'(mem_we);
        close_b   = (hdr && hdr_len == 4'd1) || (cont && left_reg == 4'd1);
        // An interrupted packet is closed with whatever words it managed to store.
        close_a   = hdr && busy_reg && (stored_reg != 4'd0);
        proto_err = (hdr && busy_reg) || (bus.i_stb && !bus.i_sof && !busy_reg)
                  || ((hdr || cont) && !mem_we) || (hdr && len_big);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg    <= 1'b0;
            lane_reg    <= 1'b0;
            left_reg    <= 4'd0;
            stored_reg  <= 4'd0;
            ca_v_reg    <= 1'b0;
            ca_lane_reg <= 1'b0;
            ca_len_reg  <= 4'd0;
            cb_v_reg    <= 1'b0;
            cb_lane_reg <= 1'b0;
            cb_len_reg  <= 4'd0;
            err_reg     <= 1'b0;
        end else begin
            ca_v_reg    <= close_a;
            ca_lane_reg <= lane_reg;
            ca_len_reg  <= stored_reg;
            cb_v_reg    <= close_b && (b_len != 4'd0);
            cb_lane_reg <= wl;
            cb_len_reg  <= b_len;
            if (proto_err)
                err_reg <= 1'b1;
            if (hdr) begin
                busy_reg   <= hdr_len != 4'd1;
                lane_reg   <= wl;
                left_reg   <= hdr_len - 4'd1;
                stored_reg <= 4'(mem_we);
            end else if (cont) begin
                busy_reg   <= left_reg != 4'd1;
                left_reg   <= left_reg - 4'd1;
                stored_reg <= b_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[{wl, wr_ptr[wl]}] <= bus.i_data;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [CW-1:0] free_reg, pkt_reg;
        logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, lq_wr_reg, lq_rd_reg;
        logic [3:0]    len_q [DEPTH];

        assign wr_en[gi]    = mem_we && (wl == 1'(gi));
        assign rd_en[gi]    = (state_reg == SEND) && (sel_reg == 1'(gi));
        assign pop[gi]      = (state_reg == IDLE) && start && (next_sel == 1'(gi));
        assign push_a[gi]   = ca_v_reg && (ca_lane_reg == 1'(gi));
        assign push_b[gi]   = cb_v_reg && (cb_lane_reg == 1'(gi));
        assign free[gi]     = free_reg;
        assign pkt_cnt[gi]  = pkt_reg;
        assign wr_ptr[gi]   = wr_ptr_reg;
        assign rd_ptr[gi]   = rd_ptr_reg;
        assign head_len[gi] = len_q[lq_rd_reg];
        assign bus.i_rdy[gi]  = free_reg >= MAXPKT;
        assign bus.i_rdyE[gi] = free_reg == FULL;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                free_reg   <= FULL;
                pkt_reg    <= '0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                lq_wr_reg  <= '0;
                lq_rd_reg  <= '0;
            end else begin
                free_reg   <= free_reg + CW'(rd_en[gi]) - CW'(wr_en[gi]);
                pkt_reg    <= pkt_reg + CW'(push_a[gi]) + CW'(push_b[gi]) - CW'(pop[gi]);
                wr_ptr_reg <= wr_ptr_reg + AW'(wr_en[gi]);
                rd_ptr_reg <= rd_ptr_reg + AW'(rd_en[gi]);
                lq_wr_reg  <= lq_wr_reg + AW'(push_a[gi]) + AW'(push_b[gi]);
                lq_rd_reg  <= lq_rd_reg + AW'(pop[gi]);
            end
        end

        // Packet lengths queue; two closes can land on one lane in the same cycle.
        always_ff @(posedge clk) begin
            if (push_a[gi])
                len_q[lq_wr_reg] <= ca_len_reg;
            if (push_b[gi])
                len_q[lq_wr_reg + AW'(push_a[gi])] <= cb_len_reg;
        end
    end

    always_comb begin
        next_sel = (pkt_cnt[1] != '0) && bus.o_rdy[1];
        start    = next_sel || ((pkt_cnt[0] != '0) && bus.o_rdy[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            sel_reg     <= 1'b0;
            first_reg   <= 1'b0;
            left_rd_reg <= 4'd0;
            o_stb_reg   <= 1'b0;
            o_sof_reg   <= 1'b0;
            o_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    o_stb_reg <= 1'b0;
                    o_sof_reg <= 1'b0;
                    if (start) begin
                        state_reg   <= SEND;
                        sel_reg     <= next_sel;
                        left_rd_reg <= head_len[next_sel];
                        first_reg   <= 1'b1;
                    end
                end
                SEND: begin
                    o_stb_reg   <= 1'b1;
                    o_sof_reg   <= first_reg;
                    first_reg   <= 1'b0;
                    o_data_reg  <= mem[{sel_reg, rd_ptr[sel_reg]}];
                    left_rd_reg <= left_rd_reg - 4'd1;
                    if (left_rd_reg == 4'd1)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_stb  = o_stb_reg;
    assign bus.o_sof  = o_sof_reg;
    assign bus.o_data = o_data_reg;
    assign bus.ff_err = err_reg;
endmodule

// File: tb/tb_rbus_pkt_buffer.sv
// Scoreboard bench for rbus_pkt_buffer (DEPTH=16): directed packets, monitor compares every output word.
module tb_rbus_pkt_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rbus_pkt_buffer_if bus();
    rbus_pkt_buffer #(.DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int words_seen = 0;
    int sof_cyc = 0;
    int last_cyc = 0;
    int t_wr = 0;
    logic [72:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.o_stb) begin
            logic [72:0] e;
            words_seen++;
            last_cyc = cyc;
            if (bus.o_sof) sof_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got sof=%0b data=%h, nothing expected", bus.o_sof, bus.o_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.o_sof, bus.o_data} !== e)
                    begin
                        bad++;
                        $display("FAIL out_word: got sof=%0b data=%h, want sof=%0b data=%h",
                                 bus.o_sof, bus.o_data, e[72], e[71:0]);
                    end
                else
                    $display("out word sof=%0b data=%h ok", bus.o_sof, bus.o_data);
            end
        end
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end else
            $display("check %s = %0h ok", name, act);
    endtask

    function automatic logic [71:0] pkt_word(input logic lane, input logic [3:0] lenf,
                                             input logic [63:0] base, input int k);
        if (k == 0) return {lane, 3'b000, lenf, base};
        return {8'hA5, base + 64'(k)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic sof, input logic [71:0] d);
        bus.i_stb  = 1'b1;
        bus.i_sof  = sof;
        bus.i_data = d;
        @(posedge clk);
        #1;
        t_wr = cyc;
        bus.i_stb = 1'b0;
        bus.i_sof = 1'b0;
    endtask

    task automatic write_pkt(input logic lane, input logic [3:0] lenf, input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++)
            put_word(k == 0, pkt_word(lane, lenf, base, k));
    endtask

    task automatic push_pkt(input logic lane, input logic [3:0] lenf, input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back({k == 0, pkt_word(lane, lenf, base, k)});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d words still pending after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sof(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.o_stb && bus.o_sof) && n < 40);
        total++;
        if (!(bus.o_stb && bus.o_sof)) begin
            bad++;
            $display("FAIL %s: no header within %0d cycles", name, n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int ws0;
        bus.i_stb  = 1'b0;
        bus.i_sof  = 1'b0;
        bus.i_data = '0;
        bus.o_rdy  = 2'b00;
        bus.o_rdyE = 2'b11;
        idle(3);
        check("rst_o_stb", bus.o_stb, 0);
        check("rst_o_sof", bus.o_sof, 0);
        check("rst_o_data", bus.o_data, 0);
        check("rst_ff_err", bus.ff_err, 0);
        check("rst_i_rdy", bus.i_rdy, 2'b11);
        check("rst_i_rdyE", bus.i_rdyE, 2'b11);
        rst = 1'b0;
        idle(1);

        // Single 4-word packet on lane 0: header three cycles after the last write.
        bus.o_rdy = 2'b11;
        push_pkt(1'b0, 4'd3, 64'h100, 4);
        write_pkt(1'b0, 4'd3, 64'h100, 4);
        t0 = t_wr;
        wait_drain("single_drain");
        check("single_hdr_latency", sof_cyc - t0, 3);
        check("single_no_gaps", last_cyc - sof_cyc, 3);
        check("single_rdyE", bus.i_rdyE, 2'b11);

        // Both lanes loaded while blocked; lane 1 must come out first.
        bus.o_rdy = 2'b00;
        write_pkt(1'b0, 4'd1, 64'h200, 2);
        write_pkt(1'b1, 4'd2, 64'h300, 3);
        push_pkt(1'b1, 4'd2, 64'h300, 3);
        push_pkt(1'b0, 4'd1, 64'h200, 2);
        idle(3);
        check("prio_stored_rdyE", bus.i_rdyE, 2'b00);
        bus.o_rdy = 2'b11;
        wait_drain("prio_drain");
        check("prio_empty", bus.i_rdyE, 2'b11);

        // Fill lane 0 to free=0, then one more header is dropped.
        bus.o_rdy = 2'b00;
        write_pkt(1'b0, 4'd8, 64'h400, 9);
        check("full_rdy_free7", bus.i_rdy, 2'b10);
        write_pkt(1'b0, 4'd6, 64'h500, 7);
        check("full_err_clean", bus.ff_err, 0);
        put_word(1'b1, pkt_word(1'b0, 4'd0, 64'h600, 0));
        check("full_drop_err", bus.ff_err, 1);
        idle(3);
        check("err_sticky", bus.ff_err, 1);
        push_pkt(1'b0, 4'd8, 64'h400, 9);
        push_pkt(1'b0, 4'd6, 64'h500, 7);
        bus.o_rdy = 2'b01;
        wait_drain("full_drain");
        check("full_after_rdyE", bus.i_rdyE, 2'b11);
        do_reset();
        check("err_cleared_by_rst", bus.ff_err, 0);

        // Stray continuation word, then an oversize length field.
        put_word(1'b0, {8'h00, 64'hDEAD});
        check("stray_err", bus.ff_err, 1);
        check("stray_lanes_untouched", bus.i_rdyE, 2'b11);
        do_reset();
        bus.o_rdy = 2'b10;
        push_pkt(1'b1, 4'd15, 64'h700, 9);
        write_pkt(1'b1, 4'd15, 64'h700, 9);
        wait_drain("clamp_drain");
        check("clamp_err", bus.ff_err, 1);
        check("clamp_rdyE", bus.i_rdyE, 2'b11);
        do_reset();

        // Blocked lane 0, then released; dropping o_rdy mid-packet does not cut it.
        bus.o_rdy = 2'b00;
        ws0 = words_seen;
        push_pkt(1'b0, 4'd4, 64'h800, 5);
        write_pkt(1'b0, 4'd4, 64'h800, 5);
        idle(6);
        check("blocked_quiet", words_seen, ws0);
        bus.o_rdy = 2'b01;
        t0 = cyc;
        wait_sof("unblock_sof");
        bus.o_rdy = 2'b00;
        wait_drain("unblock_drain");
        check("unblock_latency", sof_cyc - t0, 2);

        // Reset while word 2 of 5 is on the output, with a partial lane-1 packet pending.
        bus.o_rdy = 2'b11;
        push_pkt(1'b0, 4'd4, 64'h900, 5);
        write_pkt(1'b0, 4'd4, 64'h900, 5);
        put_word(1'b1, pkt_word(1'b1, 4'd3, 64'hA00, 0));
        put_word(1'b0, pkt_word(1'b1, 4'd3, 64'hA00, 1));
        wait_sof("midrst_sof");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_o_stb", bus.o_stb, 0);
        check("midrst_i_rdy", bus.i_rdy, 2'b11);
        check("midrst_i_rdyE", bus.i_rdyE, 2'b11);
        exp_q.delete();
        ws0 = words_seen;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);
        check("midrst_no_output", words_seen, ws0);
        check("midrst_err", bus.ff_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
